codec_intf: RTL

CODEC_INTF -- requirements
Module: codec_intf

---
 rtl/codec_intf.sv | 99 +++++++++
 1 files changed

// File: rtl/codec_intf.sv
// I2S codec interface: clock generation, 32-bit frame serializer and deserializer.
// Optional CODEC_LOOPBACK_EN feeds the receive shifter from the internal SDin bit.
module codec_intf (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] lft_out,
  input  logic signed [15:0] rht_out,
  input  logic               SDout,
  output logic               MCLK,
  output logic               SCLK,
  output logic               LRCLK,
  output logic               SDin,
  output logic               RSTn,
  output logic signed [15:0] lft_in,
  output logic signed [15:0] rht_in,
  output logic               valid
);

  logic [9:0]  cnt_q;
  logic [31:0] rx_sr_q;
  logic [31:0] shadow_q;
  logic [15:0] lft_in_q;
  logic [15:0] rht_in_q;
  logic        sdin_q;
  logic        rstn_q;
  logic        armed_q;
  logic        valid_q;

  logic        rx_bit;
  logic [31:0] rx_word_d;
  logic        sample_en;
  logic        load_en;
  logic        shift_en;

  assign sample_en = (cnt_q[4:0] == 5'h0F);
  assign load_en   = (cnt_q == 10'h01F);
  assign shift_en  = (cnt_q[4:0] == 5'h1F);

`ifdef CODEC_LOOPBACK_EN
  logic unused_sdout;
  assign unused_sdout = SDout;
  assign rx_bit       = sdin_q;
`else
  assign rx_bit = SDout;
`endif

  assign rx_word_d = {rx_sr_q[30:0], rx_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rx_sr_q  <= '0;
      shadow_q <= '0;
      lft_in_q <= '0;
      rht_in_q <= '0;
      sdin_q   <= 1'b0;
      rstn_q   <= 1'b0;
      armed_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 10'd1;
      valid_q <= 1'b0;
      // Codec reset lifts in the cycle where the counter first reads 0x3FF.
      if (cnt_q == 10'h3FE) begin
        rstn_q <= 1'b1;
      end
      if (sample_en) begin
        rx_sr_q <= rx_word_d;
        // Arm once a frame starts with the codec out of reset, so the first
        // delivered pair is a complete frame.
        if (cnt_q[9:5] == 5'd1 && rstn_q) begin
          armed_q <= 1'b1;
        end
        if (cnt_q[9:5] == 5'd0 && armed_q) begin
          lft_in_q <= rx_word_d[31:16];
          rht_in_q <= rx_word_d[15:0];
          valid_q  <= 1'b1;
        end
      end
      if (load_en) begin
        shadow_q <= {lft_out, rht_out};
        sdin_q   <= lft_out[15];
      end else if (shift_en) begin
        sdin_q   <= shadow_q[30];
        shadow_q <= {shadow_q[30:0], 1'b0};
      end
    end
  end

  assign MCLK   = cnt_q[1];
  assign SCLK   = cnt_q[4];
  assign LRCLK  = cnt_q[9];
  assign SDin   = sdin_q;
  assign RSTn   = rstn_q;
  assign lft_in = lft_in_q;
  assign rht_in = rht_in_q;
  assign valid  = valid_q;

endmodule
